// File: rtl/tlb_op_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tlb_op_ctrl
// Purpose  : Sequences TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB against a 2-port TLB
//            and returns CSR update values with a one-cycle done pulse.
// Revision : 1.0
// ============================================================================
module tlb_op_ctrl #(
    parameter int  TLBNUM = 16,
    localparam int IW     = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          resetn,

    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_op,
    input  logic [4:0]    req_inv_op,
    input  logic [9:0]    req_inv_asid,
    input  logic [18:0]   req_inv_vppn,

    input  logic [9:0]    csr_asid,
    input  logic [18:0]   csr_ehi_vppn,
    input  logic [IW-1:0] csr_idx_index,
    input  logic [5:0]    csr_idx_ps,
    input  logic          csr_idx_ne,
    input  logic [26:0]   csr_elo0,
    input  logic [26:0]   csr_elo1,

    output logic          done,
    output logic          idx_we,
    output logic          idx_ne,
    output logic [IW-1:0] idx_index,
    output logic [5:0]    idx_ps,
    output logic          rd_we,
    output logic [18:0]   rd_vppn,
    output logic [9:0]    rd_asid,
    output logic [26:0]   rd_elo0,
    output logic [26:0]   rd_elo1,

    input  logic [18:0]   mem_s1_vppn,
    input  logic          mem_s1_va_bit12,
    input  logic [9:0]    mem_s1_asid,
    output logic          mem_stall,
    output logic [18:0]   s1_vppn,
    output logic          s1_va_bit12,
    output logic [9:0]    s1_asid,
    input  logic          s1_found,
    input  logic [IW-1:0] s1_index,

    output logic          tlb_we,
    output logic [IW-1:0] w_index,
    output logic          w_e,
    output logic [18:0]   w_vppn,
    output logic [5:0]    w_ps,
    output logic [9:0]    w_asid,
    output logic          w_g,
    output logic [25:0]   w_lo0,
    output logic [25:0]   w_lo1,

    output logic [IW-1:0] r_index,
    input  logic          r_e,
    input  logic [18:0]   r_vppn,
    input  logic [5:0]    r_ps,
    input  logic [9:0]    r_asid,
    input  logic          r_g,
    input  logic [25:0]   r_lo0,
    input  logic [25:0]   r_lo1,

    output logic          invtlb_valid,
    output logic [4:0]    invtlb_op
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] c_op_srch   = 3'd0;
    localparam logic [2:0] c_op_rd     = 3'd1;
    localparam logic [2:0] c_op_wr     = 3'd2;
    localparam logic [2:0] c_op_fill   = 3'd3;
    localparam logic [2:0] c_op_inv    = 3'd4;
    localparam logic [4:0] c_inv_max   = 5'd6;
    localparam logic [IW-1:0] c_fill_last = IW'(TLBNUM - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_accept;

    // Operands frozen at accept so CSR writes in flight cannot disturb the op
    logic [2:0]    r_lat_op;
    logic [4:0]    r_lat_inv_op;
    logic [9:0]    r_lat_inv_asid;
    logic [18:0]   r_lat_inv_vppn;
    logic [9:0]    r_lat_asid;
    logic [18:0]   r_lat_ehi_vppn;
    logic [IW-1:0] r_lat_idx_index;
    logic [5:0]    r_lat_idx_ps;
    logic          r_lat_idx_ne;
    logic [26:0]   r_lat_elo0;
    logic [26:0]   r_lat_elo1;

    logic          r_res_ne;
    logic [IW-1:0] r_res_index;
    logic [5:0]    r_res_ps;
    logic [18:0]   r_rd_vppn;
    logic [9:0]    r_rd_asid;
    logic [26:0]   r_rd_elo0;
    logic [26:0]   r_rd_elo1;

    logic [IW-1:0] r_fill_ptr;

    logic          w_in_exec;
    logic          w_in_done;

    assign w_accept  = req_valid && (r_state == ST_IDLE);
    assign w_in_exec = (r_state == ST_EXEC);
    assign w_in_done = (r_state == ST_DONE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        req_ready    = 1'b0;
        done         = 1'b0;
        idx_we       = 1'b0;
        rd_we        = 1'b0;
        tlb_we       = 1'b0;
        invtlb_valid = 1'b0;
        mem_stall    = 1'b0;
        s1_vppn      = mem_s1_vppn;
        s1_va_bit12  = mem_s1_va_bit12;
        s1_asid      = mem_s1_asid;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (w_accept) begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_DONE;
                case (r_lat_op)
                    c_op_srch: begin
                        mem_stall   = 1'b1;
                        s1_vppn     = r_lat_ehi_vppn;
                        s1_asid     = r_lat_asid;
                        s1_va_bit12 = 1'b0;
                    end
                    c_op_wr, c_op_fill: begin
                        tlb_we = 1'b1;
                    end
                    c_op_inv: begin
                        mem_stall    = 1'b1;
                        s1_vppn      = r_lat_inv_vppn;
                        s1_asid      = r_lat_inv_asid;
                        s1_va_bit12  = 1'b0;
                        invtlb_valid = (r_lat_inv_op <= c_inv_max);
                    end
                    default: ;
                endcase
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                done        = 1'b1;
                idx_we      = (r_lat_op == c_op_srch) || (r_lat_op == c_op_rd);
                rd_we       = (r_lat_op == c_op_rd);
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_lat_op        <= '0;
            r_lat_inv_op    <= '0;
            r_lat_inv_asid  <= '0;
            r_lat_inv_vppn  <= '0;
            r_lat_asid      <= '0;
            r_lat_ehi_vppn  <= '0;
            r_lat_idx_index <= '0;
            r_lat_idx_ps    <= '0;
            r_lat_idx_ne    <= 1'b0;
            r_lat_elo0      <= '0;
            r_lat_elo1      <= '0;
        end else if (w_accept) begin
            r_lat_op        <= req_op;
            r_lat_inv_op    <= req_inv_op;
            r_lat_inv_asid  <= req_inv_asid;
            r_lat_inv_vppn  <= req_inv_vppn;
            r_lat_asid      <= csr_asid;
            r_lat_ehi_vppn  <= csr_ehi_vppn;
            r_lat_idx_index <= csr_idx_index;
            r_lat_idx_ps    <= csr_idx_ps;
            r_lat_idx_ne    <= csr_idx_ne;
            r_lat_elo0      <= csr_elo0;
            r_lat_elo1      <= csr_elo1;
        end
    end

    // Search and read results are sampled on the last edge of EXEC
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_res_ne    <= 1'b0;
            r_res_index <= '0;
            r_res_ps    <= '0;
            r_rd_vppn   <= '0;
            r_rd_asid   <= '0;
            r_rd_elo0   <= '0;
            r_rd_elo1   <= '0;
        end else if (w_in_exec) begin
            if (r_lat_op == c_op_srch) begin
                r_res_ne    <= ~s1_found;
                r_res_index <= s1_found ? s1_index : r_lat_idx_index;
                r_res_ps    <= r_lat_idx_ps;
            end else if (r_lat_op == c_op_rd) begin
                r_res_index <= r_lat_idx_index;
                if (r_e) begin
                    r_res_ne  <= 1'b0;
                    r_res_ps  <= r_ps;
                    r_rd_vppn <= r_vppn;
                    r_rd_asid <= r_asid;
                    r_rd_elo0 <= {r_lo0[25:6], r_g, r_lo0[5:0]};
                    r_rd_elo1 <= {r_lo1[25:6], r_g, r_lo1[5:0]};
                end else begin
                    r_res_ne  <= 1'b1;
                    r_res_ps  <= '0;
                    r_rd_vppn <= '0;
                    r_rd_asid <= '0;
                    r_rd_elo0 <= '0;
                    r_rd_elo1 <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_fill_ptr <= '0;
        end else if (w_in_exec && (r_lat_op == c_op_fill)) begin
            r_fill_ptr <= (r_fill_ptr == c_fill_last) ? '0 : r_fill_ptr + IW'(1);
        end
    end

    assign idx_ne    = r_res_ne;
    assign idx_index = r_res_index;
    assign idx_ps    = r_res_ps;
    assign rd_vppn   = r_rd_vppn;
    assign rd_asid   = r_rd_asid;
    assign rd_elo0   = r_rd_elo0;
    assign rd_elo1   = r_rd_elo1;

    // Entry write fields: the global bit is shared by both pages of the pair
    assign w_index = (r_lat_op == c_op_fill) ? r_fill_ptr : r_lat_idx_index;
    assign w_e     = ~r_lat_idx_ne;
    assign w_vppn  = r_lat_ehi_vppn;
    assign w_ps    = r_lat_idx_ps;
    assign w_asid  = r_lat_asid;
    assign w_g     = r_lat_elo0[6] & r_lat_elo1[6];
    assign w_lo0   = {r_lat_elo0[26:7], r_lat_elo0[5:0]};
    assign w_lo1   = {r_lat_elo1[26:7], r_lat_elo1[5:0]};

    assign r_index   = r_lat_idx_index;
    assign invtlb_op = r_lat_inv_op;

    logic w_unused;
    assign w_unused = w_in_done;

endmodule
`default_nettype wire

// File: tb/tb_tlb_op_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tlb_op_ctrl
// Purpose  : Self-checking bench for tlb_op_ctrl with a behavioural TLB model.
// Revision : 1.0
// ============================================================================
module tb_tlb_op_ctrl;

    localparam int TLBNUM = 16;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid, req_ready;
    logic [2:0]  req_op;
    logic [4:0]  req_inv_op;
    logic [9:0]  req_inv_asid;
    logic [18:0] req_inv_vppn;
    logic [9:0]  csr_asid;
    logic [18:0] csr_ehi_vppn;
    logic [3:0]  csr_idx_index;
    logic [5:0]  csr_idx_ps;
    logic        csr_idx_ne;
    logic [26:0] csr_elo0, csr_elo1;
    logic        done, idx_we, idx_ne, rd_we;
    logic [3:0]  idx_index;
    logic [5:0]  idx_ps;
    logic [18:0] rd_vppn;
    logic [9:0]  rd_asid;
    logic [26:0] rd_elo0, rd_elo1;
    logic [18:0] mem_s1_vppn;
    logic        mem_s1_va_bit12;
    logic [9:0]  mem_s1_asid;
    logic        mem_stall;
    logic [18:0] s1_vppn;
    logic        s1_va_bit12;
    logic [9:0]  s1_asid;
    logic        s1_found;
    logic [3:0]  s1_index;
    logic        tlb_we, w_e, w_g;
    logic [3:0]  w_index;
    logic [18:0] w_vppn;
    logic [5:0]  w_ps;
    logic [9:0]  w_asid;
    logic [25:0] w_lo0, w_lo1;
    logic [3:0]  r_index;
    logic        r_e, r_g;
    logic [18:0] r_vppn;
    logic [5:0]  r_ps;
    logic [9:0]  r_asid;
    logic [25:0] r_lo0, r_lo1;
    logic        invtlb_valid;
    logic [4:0]  invtlb_op;

    tlb_op_ctrl #(.TLBNUM(TLBNUM)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_inv_op(req_inv_op), .req_inv_asid(req_inv_asid), .req_inv_vppn(req_inv_vppn),
        .csr_asid(csr_asid), .csr_ehi_vppn(csr_ehi_vppn), .csr_idx_index(csr_idx_index),
        .csr_idx_ps(csr_idx_ps), .csr_idx_ne(csr_idx_ne), .csr_elo0(csr_elo0), .csr_elo1(csr_elo1),
        .done(done), .idx_we(idx_we), .idx_ne(idx_ne), .idx_index(idx_index), .idx_ps(idx_ps),
        .rd_we(rd_we), .rd_vppn(rd_vppn), .rd_asid(rd_asid), .rd_elo0(rd_elo0), .rd_elo1(rd_elo1),
        .mem_s1_vppn(mem_s1_vppn), .mem_s1_va_bit12(mem_s1_va_bit12), .mem_s1_asid(mem_s1_asid),
        .mem_stall(mem_stall), .s1_vppn(s1_vppn), .s1_va_bit12(s1_va_bit12), .s1_asid(s1_asid),
        .s1_found(s1_found), .s1_index(s1_index),
        .tlb_we(tlb_we), .w_index(w_index), .w_e(w_e), .w_vppn(w_vppn), .w_ps(w_ps),
        .w_asid(w_asid), .w_g(w_g), .w_lo0(w_lo0), .w_lo1(w_lo1),
        .r_index(r_index), .r_e(r_e), .r_vppn(r_vppn), .r_ps(r_ps), .r_asid(r_asid),
        .r_g(r_g), .r_lo0(r_lo0), .r_lo1(r_lo1),
        .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op)
    );

    // Behavioural TLB: array storage, first-match search, INVTLB semantics
    logic        t_e    [TLBNUM];
    logic [18:0] t_vppn [TLBNUM];
    logic [5:0]  t_ps   [TLBNUM];
    logic [9:0]  t_asid [TLBNUM];
    logic        t_g    [TLBNUM];
    logic [25:0] t_lo0  [TLBNUM];
    logic [25:0] t_lo1  [TLBNUM];
    logic        tlb_clr;

    function automatic logic inv_kill(input logic [4:0] op, input logic g, input logic [9:0] a,
                                      input logic [18:0] vp, input logic [9:0] sa, input logic [18:0] sv);
        case (op)
            5'd0, 5'd1: return 1'b1;
            5'd2:       return g;
            5'd3:       return !g;
            5'd4:       return !g && (a == sa);
            5'd5:       return !g && (a == sa) && (vp == sv);
            5'd6:       return (g || (a == sa)) && (vp == sv);
            default:    return 1'b0;
        endcase
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < TLBNUM; i++) begin
            if (tlb_clr) begin
                t_e[i] <= 1'b0; t_vppn[i] <= '0; t_ps[i] <= '0; t_asid[i] <= '0;
                t_g[i] <= 1'b0; t_lo0[i] <= '0; t_lo1[i] <= '0;
            end else if (tlb_we && (w_index == 4'(i))) begin
                t_e[i] <= w_e; t_vppn[i] <= w_vppn; t_ps[i] <= w_ps; t_asid[i] <= w_asid;
                t_g[i] <= w_g; t_lo0[i] <= w_lo0; t_lo1[i] <= w_lo1;
            end else if (invtlb_valid && inv_kill(invtlb_op, t_g[i], t_asid[i], t_vppn[i], s1_asid, s1_vppn)) begin
                t_e[i] <= 1'b0;
            end
        end
    end

    function automatic void lookup(input logic [18:0] vp, input logic [9:0] as,
                                   output logic f, output logic [3:0] ix);
        f = 1'b0; ix = '0;
        for (int i = 0; i < TLBNUM; i++)
            if (!f && t_e[i] && (t_vppn[i] == vp) && (t_g[i] || (t_asid[i] == as))) begin
                f = 1'b1; ix = 4'(i);
            end
    endfunction

    always_comb lookup(s1_vppn, s1_asid, s1_found, s1_index);

    assign r_e    = t_e[r_index];
    assign r_vppn = t_vppn[r_index];
    assign r_ps   = t_ps[r_index];
    assign r_asid = t_asid[r_index];
    assign r_g    = t_g[r_index];
    assign r_lo0  = t_lo0[r_index];
    assign r_lo1  = t_lo1[r_index];

    typedef struct {
        logic [2:0]  op;
        logic [18:0] vppn;
        logic [9:0]  asid;
        logic [3:0]  idx;
        logic [5:0]  ps;
        logic        ne;
        logic [26:0] elo0, elo1;
        logic [4:0]  inv_op;
        logic [9:0]  inv_asid;
        logic [18:0] inv_vppn;
    } op_t;

    typedef struct {
        logic        stall, tlb_we, inv_valid, idx_we, ne, rd_we;
        logic [3:0]  w_index, index;
        logic [5:0]  ps;
        logic [18:0] rd_vppn;
        logic [9:0]  rd_asid;
        logic [26:0] rd_elo0, rd_elo1;
    } exp_t;

    typedef struct { op_t v; exp_t e; } vec_t;

    int n_vec = 0;
    int n_bad = 0;
    int fill_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic op_t mk_op(input logic [2:0] op, input logic [18:0] vppn, input logic [9:0] asid,
                                  input logic [3:0] idx, input logic [5:0] ps, input logic ne,
                                  input logic [26:0] e0, input logic [26:0] e1, input logic [4:0] iop,
                                  input logic [9:0] ias, input logic [18:0] ivp);
        op_t v;
        v.op = op; v.vppn = vppn; v.asid = asid; v.idx = idx; v.ps = ps; v.ne = ne;
        v.elo0 = e0; v.elo1 = e1; v.inv_op = iop; v.inv_asid = ias; v.inv_vppn = ivp;
        return v;
    endfunction

    function automatic exp_t mk_exp(input logic stall, input logic twe, input logic [3:0] widx,
                                    input logic inv, input logic iwe, input logic ne,
                                    input logic [3:0] index, input logic [5:0] ps, input logic rwe,
                                    input logic [18:0] rv, input logic [9:0] ra,
                                    input logic [26:0] r0, input logic [26:0] r1);
        exp_t e;
        e.stall = stall; e.tlb_we = twe; e.w_index = widx; e.inv_valid = inv; e.idx_we = iwe;
        e.ne = ne; e.index = index; e.ps = ps; e.rd_we = rwe; e.rd_vppn = rv; e.rd_asid = ra;
        e.rd_elo0 = r0; e.rd_elo1 = r1;
        return e;
    endfunction

    // Reference model: expected outcome of one op given the current TLB contents
    function automatic exp_t predict(input op_t v);
        exp_t e;
        logic f;
        logic [3:0] hit;
        logic [25:0] l0, l1;
        e = mk_exp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        case (v.op)
            3'd0: begin
                lookup(v.vppn, v.asid, f, hit);
                e.stall = 1; e.idx_we = 1; e.ne = !f;
                e.index = f ? hit : v.idx; e.ps = v.ps;
            end
            3'd1: begin
                e.idx_we = 1; e.rd_we = 1; e.index = v.idx;
                if (t_e[v.idx]) begin
                    l0 = t_lo0[v.idx]; l1 = t_lo1[v.idx];
                    e.ne = 0; e.ps = t_ps[v.idx];
                    e.rd_vppn = t_vppn[v.idx]; e.rd_asid = t_asid[v.idx];
                    e.rd_elo0 = {l0[25:6], t_g[v.idx], l0[5:0]};
                    e.rd_elo1 = {l1[25:6], t_g[v.idx], l1[5:0]};
                end else begin
                    e.ne = 1;
                end
            end
            3'd2: begin e.tlb_we = 1; e.w_index = v.idx; end
            3'd3: begin e.tlb_we = 1; e.w_index = 4'(fill_cnt % TLBNUM); end
            3'd4: begin e.stall = 1; e.inv_valid = (v.inv_op <= 5'd6); end
            default: ;
        endcase
        return e;
    endfunction

    task automatic drive_req(input op_t v);
        req_op = v.op; req_inv_op = v.inv_op; req_inv_asid = v.inv_asid; req_inv_vppn = v.inv_vppn;
        csr_asid = v.asid; csr_ehi_vppn = v.vppn; csr_idx_index = v.idx; csr_idx_ps = v.ps;
        csr_idx_ne = v.ne; csr_elo0 = v.elo0; csr_elo1 = v.elo1;
    endtask

    task automatic scramble_req();
        req_op = 3'($urandom); req_inv_op = 5'($urandom); req_inv_asid = 10'($urandom);
        req_inv_vppn = 19'($urandom); csr_asid = 10'($urandom); csr_ehi_vppn = 19'($urandom);
        csr_idx_index = 4'($urandom); csr_idx_ps = 6'($urandom); csr_idx_ne = 1'($urandom);
        csr_elo0 = 27'($urandom); csr_elo1 = 27'($urandom);
    endtask

    task automatic run_op(input op_t v, input exp_t e, input string tag);
        int guard;
        logic [18:0] x_vppn;
        logic [9:0]  x_asid;
        logic        x_b12;
        drive_req(v);
        mem_s1_vppn = 19'($urandom); mem_s1_asid = 10'($urandom); mem_s1_va_bit12 = 1'($urandom);
        req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 10) begin @(posedge clk); #1; guard++; end
        if (!req_ready) begin
            chk({tag, "_ready_timeout"}, 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        scramble_req();
        // EXEC cycle
        chk({tag, "_exec_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_exec_done"}, 32'(done), 32'd0);
        chk({tag, "_exec_stall"}, 32'(mem_stall), 32'(e.stall));
        chk({tag, "_exec_tlb_we"}, 32'(tlb_we), 32'(e.tlb_we));
        chk({tag, "_exec_inv_valid"}, 32'(invtlb_valid), 32'(e.inv_valid));
        if (e.tlb_we) begin
            chk({tag, "_w_index"}, 32'(w_index), 32'(e.w_index));
            chk({tag, "_w_e"}, 32'(w_e), 32'(!v.ne));
            chk({tag, "_w_vppn"}, 32'(w_vppn), 32'(v.vppn));
            chk({tag, "_w_ps"}, 32'(w_ps), 32'(v.ps));
            chk({tag, "_w_asid"}, 32'(w_asid), 32'(v.asid));
            chk({tag, "_w_g"}, 32'(w_g), 32'(v.elo0[6] & v.elo1[6]));
            chk({tag, "_w_lo0"}, 32'(w_lo0), 32'({v.elo0[26:7], v.elo0[5:0]}));
            chk({tag, "_w_lo1"}, 32'(w_lo1), 32'({v.elo1[26:7], v.elo1[5:0]}));
        end
        if (e.inv_valid) chk({tag, "_inv_op"}, 32'(invtlb_op), 32'(v.inv_op));
        if (v.op == 3'd0) begin
            x_vppn = v.vppn; x_asid = v.asid; x_b12 = 1'b0;
        end else if (v.op == 3'd4) begin
            x_vppn = v.inv_vppn; x_asid = v.inv_asid; x_b12 = 1'b0;
        end else begin
            x_vppn = mem_s1_vppn; x_asid = mem_s1_asid; x_b12 = mem_s1_va_bit12;
        end
        chk({tag, "_s1_vppn"}, 32'(s1_vppn), 32'(x_vppn));
        chk({tag, "_s1_asid"}, 32'(s1_asid), 32'(x_asid));
        chk({tag, "_s1_b12"}, 32'(s1_va_bit12), 32'(x_b12));
        if (v.op == 3'd1) chk({tag, "_r_index"}, 32'(r_index), 32'(v.idx));
        if (v.op == 3'd3) fill_cnt++;
        @(posedge clk); #1;
        // DONE cycle
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_done_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_idx_we"}, 32'(idx_we), 32'(e.idx_we));
        chk({tag, "_rd_we"}, 32'(rd_we), 32'(e.rd_we));
        chk({tag, "_done_strobes"}, 32'({tlb_we, invtlb_valid, mem_stall}), 32'd0);
        if (e.idx_we) begin
            chk({tag, "_idx_ne"}, 32'(idx_ne), 32'(e.ne));
            chk({tag, "_idx_index"}, 32'(idx_index), 32'(e.index));
            chk({tag, "_idx_ps"}, 32'(idx_ps), 32'(e.ps));
        end
        if (e.rd_we) begin
            chk({tag, "_rd_vppn"}, 32'(rd_vppn), 32'(e.rd_vppn));
            chk({tag, "_rd_asid"}, 32'(rd_asid), 32'(e.rd_asid));
            chk({tag, "_rd_elo0"}, 32'(rd_elo0), 32'(e.rd_elo0));
            chk({tag, "_rd_elo1"}, 32'(rd_elo1), 32'(e.rd_elo1));
        end
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
    endtask

    localparam logic [26:0] E0A = {20'h11111, 1'b1, 2'd1, 2'd0, 1'b1, 1'b1};
    localparam logic [26:0] E1A = {20'h22222, 1'b0, 2'd2, 2'd3, 1'b0, 1'b1};
    localparam logic [26:0] E0B = {20'hAAAAA, 1'b1, 2'd1, 2'd2, 1'b1, 1'b1};
    localparam logic [26:0] E1B = {20'h55555, 1'b1, 2'd0, 2'd1, 1'b1, 1'b0};

    vec_t tbl[11];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        op_t  v;
        exp_t e;

        tbl[0]  = '{mk_op(2, 19'h12345, 3, 5, 12, 0, E0A, E1A, 0, 0, 0),
                    mk_exp(0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[1]  = '{mk_op(0, 19'h12345, 3, 7, 12, 0, 0, 0, 0, 0, 0),
                    mk_exp(1, 0, 0, 0, 1, 0, 5, 12, 0, 0, 0, 0, 0)};
        tbl[2]  = '{mk_op(0, 19'h12345, 4, 7, 12, 0, 0, 0, 0, 0, 0),
                    mk_exp(1, 0, 0, 0, 1, 1, 7, 12, 0, 0, 0, 0, 0)};
        tbl[3]  = '{mk_op(2, 19'h0ABCD, 7, 9, 22, 0, E0B, E1B, 0, 0, 0),
                    mk_exp(0, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[4]  = '{mk_op(1, 19'h7FFFF, 1, 9, 3, 1, 0, 0, 0, 0, 0),
                    mk_exp(0, 0, 0, 0, 1, 0, 9, 22, 1, 19'h0ABCD, 7, E0B, E1B)};
        tbl[5]  = '{mk_op(1, 19'h7FFFF, 1, 2, 17, 0, 0, 0, 0, 0, 0),
                    mk_exp(0, 0, 0, 0, 1, 1, 2, 0, 1, 0, 0, 0, 0)};
        tbl[6]  = '{mk_op(4, 0, 0, 0, 0, 0, 0, 0, 5, 3, 19'h12345),
                    mk_exp(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[7]  = '{mk_op(0, 19'h12345, 3, 11, 5, 0, 0, 0, 0, 0, 0),
                    mk_exp(1, 0, 0, 0, 1, 1, 11, 5, 0, 0, 0, 0, 0)};
        tbl[8]  = '{mk_op(4, 0, 0, 0, 0, 0, 0, 0, 9, 3, 19'h0ABCD),
                    mk_exp(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[9]  = '{mk_op(6, 19'h0ABCD, 7, 9, 22, 0, E0B, E1B, 0, 0, 0),
                    mk_exp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[10] = '{mk_op(5, 19'h0ABCD, 7, 9, 22, 0, E0B, E1B, 5, 7, 19'h0ABCD),
                    mk_exp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};

        req_valid = 1'b0; tlb_clr = 1'b1;
        scramble_req();
        mem_s1_vppn = 19'h3C3C3; mem_s1_asid = 10'h2A5; mem_s1_va_bit12 = 1'b1;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1; tlb_clr = 1'b0;
        @(posedge clk); #1;
        chk("reset_ready", 32'(req_ready), 32'd1);
        chk("reset_strobes", 32'({done, idx_we, rd_we, tlb_we, invtlb_valid, mem_stall}), 32'd0);
        chk("reset_idx", 32'({idx_ne, idx_index, idx_ps}), 32'd0);
        chk("reset_rd", 32'({rd_vppn, rd_asid}), 32'd0);
        chk("reset_s1_pass", 32'({s1_va_bit12, s1_vppn}), 32'({mem_s1_va_bit12, mem_s1_vppn}));

        for (int i = 0; i < 11; i++) run_op(tbl[i].v, tbl[i].e, $sformatf("tbl%0d", i));

        // FILL wraps the round-robin pointer after TLBNUM entries
        for (int i = 0; i < 17; i++) begin
            v = mk_op(3, 19'(i), 10'(i), 4'($urandom), 6'd12, 0, 27'($urandom), 27'($urandom), 0, 0, 0);
            e = predict(v);
            chk($sformatf("fill%0d_model_idx", i), 32'(e.w_index), 32'(i % 16));
            run_op(v, e, $sformatf("fill%0d", i));
        end

        // Continuous request: one accept every third cycle
        req_op = 3'd7; req_valid = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            chk($sformatf("hs%0d_ready", k), 32'(req_ready), 32'(k % 3 == 2));
            chk($sformatf("hs%0d_done", k), 32'(done), 32'(k % 3 == 1));
        end
        req_valid = 1'b0;
        @(posedge clk); #1;

        for (int n = 0; n < 80; n++) begin
            v = mk_op(3'($urandom), {17'h0, 2'($urandom)}, 10'($urandom_range(0, 3)), 4'($urandom),
                      6'($urandom), 1'($urandom_range(0, 3) == 0), 27'($urandom), 27'($urandom),
                      5'($urandom_range(0, 9)), 10'($urandom_range(0, 3)), {17'h0, 2'($urandom)});
            e = predict(v);
            run_op(v, e, $sformatf("rnd%0d", n));
        end

        // Reset in the middle of a WR EXEC cycle
        drive_req(mk_op(2, 19'h1, 1, 3, 12, 0, E0A, E0B, 0, 0, 0));
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rst_pre_tlb_we", 32'(tlb_we), 32'd1);
        resetn = 1'b0;
        #1;
        chk("rst_strobes", 32'({done, idx_we, rd_we, tlb_we, invtlb_valid, mem_stall}), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        chk("rst_no_done", 32'(done), 32'd0);
        resetn = 1'b1;
        fill_cnt = 0;
        @(posedge clk); #1;
        chk("rst_post_done", 32'(done), 32'd0);
        chk("rst_post_ready", 32'(req_ready), 32'd1);
        v = mk_op(3, 19'h7, 2, 9, 12, 0, E0A, E1A, 0, 0, 0);
        e = predict(v);
        chk("rst_fill_model_idx", 32'(e.w_index), 32'd0);
        run_op(v, e, "rst_fill");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tlb_op_ctrl.md
Name: tlb_op_ctrl

Overview:
Sequences the privileged TLB instructions TLBSRCH, TLBRD, TLBWR, TLBFILL and INVTLB against the 2-port TLB.
Takes one op at a time from the writeback stage through a valid/ready handshake and drives the TLB write, read and invalidate ports.
Borrows search port 1 from the load/store path while it runs, and stalls that path meanwhile.
Returns CSR update values (TLBIDX, TLBEHI, TLBELO0/1, ASID) with a one-cycle done pulse.

Parameters:
TLBNUM, 16, number of TLB entries; IW = $clog2(TLBNUM) is the index width.

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
req_valid  in  1  op request
req_ready  out  1  controller can accept an op
req_op  in  3  0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV; 5-7 are no-ops
req_inv_op  in  5  INVTLB op code
req_inv_asid  in  10  INVTLB rj ASID
req_inv_vppn  in  19  INVTLB rk VA[31:13]
csr_asid  in  10  ASID.asid
csr_ehi_vppn  in  19  TLBEHI.vppn
csr_idx_index  in  IW  TLBIDX.index
csr_idx_ps  in  6  TLBIDX.ps
csr_idx_ne  in  1  TLBIDX.ne
csr_elo0, csr_elo1  in  27 each  {ppn[19:0], g, mat[1:0], plv[1:0], d, v}
done  out  1  op-complete pulse
idx_we  out  1  write TLBIDX (SRCH, RD)
idx_ne  out  1  TLBIDX.ne value
idx_index  out  IW  TLBIDX.index value
idx_ps  out  6  TLBIDX.ps value
rd_we  out  1  write TLBEHI, TLBELO0/1 and ASID (RD only)
rd_vppn  out  19  TLBEHI.vppn value
rd_asid  out  10  ASID.asid value
rd_elo0, rd_elo1  out  27 each  TLBELO values, same packing as csr_elo*
mem_s1_vppn  in  19  load/store search VPPN
mem_s1_va_bit12  in  1  load/store VA[12]
mem_s1_asid  in  10  load/store ASID
mem_stall  out  1  search port 1 is owned by the controller
s1_vppn  out  19  TLB search port 1 VPPN
s1_va_bit12  out  1  TLB search port 1 VA[12]
s1_asid  out  10  TLB search port 1 ASID
s1_found  in  1  search hit
s1_index  in  IW  hit index
tlb_we  out  1  TLB write enable
w_index  out  IW  write index
w_e  out  1  entry exists
w_vppn  out  19  entry VPPN
w_ps  out  6  entry page size
w_asid  out  10  entry ASID
w_g  out  1  entry global bit
w_lo0, w_lo1  out  26 each  {ppn, mat, plv, d, v} for even/odd page
r_index  out  IW  read index
r_e  in  1  read entry exists
r_vppn  in  19  read VPPN
r_ps  in  6  read page size
r_asid  in  10  read ASID
r_g  in  1  read global bit
r_lo0, r_lo1  in  26 each  read page fields
invtlb_valid  out  1  invalidate strobe
invtlb_op  out  5  invalidate op

Behaviour:
- States: IDLE, EXEC, DONE.
- req_ready = (state==IDLE).
- IDLE -> EXEC on req_valid & req_ready. At accept, latch req_op, the three INV operands and all csr_* inputs.
- EXEC -> DONE unconditionally. DONE -> IDLE unconditionally.
- Accept at edge T gives done high in cycle T+2; back-to-back throughput is 1 op per 3 cycles.
- Port ownership: outside EXEC, s1_* = mem_s1_* (pass-through) and mem_stall = 0.
- In EXEC with op SRCH: s1_vppn = latched ehi_vppn, s1_asid = latched asid, s1_va_bit12 = 0, mem_stall = 1.
- In EXEC with op INV: s1_vppn = req_inv_vppn, s1_asid = req_inv_asid (latched values), s1_va_bit12 = 0, mem_stall = 1.
- SRCH: at the end of EXEC, capture s1_found/s1_index.
  - In DONE: idx_we = 1. On a hit, idx_ne = 0 and idx_index = s1_index. On a miss, idx_ne = 1 and idx_index = latched csr_idx_index.
  - idx_ps = latched csr_idx_ps.
- RD: in EXEC, r_index = latched index; capture r_* at the end of EXEC.
  - In DONE: idx_we = 1 and rd_we = 1.
  - If r_e = 1: idx_ne = 0, idx_ps = r_ps, rd_vppn/rd_asid = r_vppn/r_asid, rd_elo0/rd_elo1 = r_lo0/r_lo1 with g = r_g inserted.
  - If r_e = 0: idx_ne = 1, idx_ps = 0, and all rd_* = 0.
  - idx_index = latched index in both cases.
- WR/FILL: tlb_we = 1 for exactly the EXEC cycle.
  - w_index = latched csr_idx_index for WR; fill_ptr for FILL.
  - w_e = ~ne, w_vppn = ehi_vppn, w_ps = idx_ps, w_asid = asid.
  - w_g = elo0.g & elo1.g; w_lo0/w_lo1 = elo0/elo1 with g removed.
- fill_ptr: IW-bit round-robin counter, reset 0, +1 at the end of each FILL EXEC; wraps TLBNUM-1 -> 0.
- INV: invtlb_valid = 1 for the EXEC cycle, invtlb_op = latched inv op.
  - If the inv op > 6: invtlb_valid stays 0 and done still pulses.
- req_op 5-7: pass through EXEC and DONE with no TLB or CSR activity; done pulses.
- Outside their defining state: tlb_we, invtlb_valid, done, idx_we, rd_we = 0. Data outputs are don't-care while their enable is 0; idx_* and rd_* hold registered values.
- Reset (async, any state, including mid-EXEC): state = IDLE, fill_ptr = 0, all captured registers = 0, all strobes = 0. A partially issued op is dropped; no done pulse.

Test Plan:
- SRCH hit: TLB entry 5 = {vppn 0x12345, asid 3, e 1}; SRCH with ehi 0x12345, asid 3 -> mem_stall high only in EXEC; done at T+2 with idx_we = 1, ne = 0, index = 5. Repeat with asid 4 and g = 0 -> ne = 1, index unchanged.
- WR then RD: WR at index 9, ps 22, elo0.g = elo1.g = 1, ne = 0 -> tlb_we for one cycle with w_g = 1. RD index 9 -> rd_we = 1, idx_ps = 22, fields equal the written values. RD of an empty index -> ne = 1, all rd_* = 0.
- FILL x17 -> w_index sequence 0, 1, ... 15, 0 (wrap).
- INV op 5 with asid 3 and vppn of entry 5 -> invtlb_valid pulse with invtlb_op = 5; s1_* carry the INV operands. INV op 9 -> no invtlb_valid, done still pulses.
- Handshake: hold req_valid high continuously -> accepts spaced exactly 3 cycles apart; req_ready = 0 in EXEC and DONE.
- Reset asserted during a WR EXEC cycle -> all strobes drop immediately, no done; after release, req_ready = 1 and fill_ptr = 0.
